muldiv_sequencer: RTL and testbench

Multi-cycle RV32M multiply/divide unit that sits beside the ALU in the execute stage. It accepts one M-extension operation from the execute stage, holds the pipeline through a stall request while it iterates, and returns a single-cycle result pulse that the execute stage muxes onto its calculation output. Operands arrive already forwarded, so the block owns only sequencing, sign handling and RISC-V corner-case results.

---
 rtl/multicore_pkg.sv | 40 ++++
 rtl/muldiv_iter_core.sv | 62 ++++++
 rtl/muldiv_sequencer.sv | 158 +++++++++++++++
 tb/tb_muldiv_sequencer.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/multicore_pkg.sv
// Shared types for the execute-stage multiply/divide unit.
package multicore_pkg;

  localparam int DATA_SIZE    = 32;
  localparam int MULDIV_ITERS = 32;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } t_mdop;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } t_muldiv_state;

  // Result source select used by the execute stage output mux.
  typedef enum logic [1:0] {
    ALU_UNIT    = 2'd0,
    LSU_UNIT    = 2'd1,
    BRANCH_UNIT = 2'd2,
    MULDIV_UNIT = 2'd3
  } t_exe_unit;

  function automatic logic md_is_div(input t_mdop op);
    return op[2];
  endfunction

  function automatic logic md_is_rem(input t_mdop op);
    return op == REM || op == REMU;
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Iterative datapath: 2W-bit shift register, add/subtract step and down-counter.
// With MULDIV_FAST_MUL_EN defined only the divide step is built.
module muldiv_iter_core #(
  parameter int W = 32
) (
  input  logic           i_aclk,
  input  logic           i_areset_n,
  input  logic           i_load,
  input  logic           i_step,
  input  logic           i_div,
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic [2*W-1:0] o_acc_next,
  output logic           o_last
);

  localparam int CW = $clog2(multicore_pkg::MULDIV_ITERS);

  logic [2*W-1:0] acc_q;
  logic [W-1:0]   b_q;
  logic [CW-1:0]  cnt_q;
  logic [W:0]     sub;

  // Trial subtract of the divisor from the remainder shifted left by one.
  assign sub = acc_q[2*W-1:W-1] - {1'b0, b_q};

`ifndef MULDIV_FAST_MUL_EN
  logic [W:0] sum;
  assign sum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, b_q} : '0);
`endif

  always_comb begin
    o_acc_next = acc_q;
    if (i_div) begin
      if (!sub[W]) o_acc_next = {sub[W-1:0], acc_q[W-2:0], 1'b1};
      else         o_acc_next = {acc_q[2*W-2:0], 1'b0};
    end
`ifndef MULDIV_FAST_MUL_EN
    else begin
      o_acc_next = {sum, acc_q[W-1:1]};
    end
`endif
  end

  assign o_last = (cnt_q == '0);

  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      acc_q <= '0;
      b_q   <= '0;
      cnt_q <= '0;
    end else if (i_load) begin
      acc_q <= {{W{1'b0}}, i_a};
      b_q   <= i_b;
      cnt_q <= CW'(multicore_pkg::MULDIV_ITERS - 1);
    end else if (i_step) begin
      acc_q <= o_acc_next;
      cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer: FSM, operand sign conditioning, special cases, final sign fix.
// MULDIV_FAST_MUL_EN selects a single-cycle 33x33 multiplier for the multiply ops.
//
// state | meaning
// IDLE  | waiting for i_start; special cases resolve here
// RUN   | one shift-add / shift-subtract iteration per cycle
// DONE  | o_done pulse, result presented
module muldiv_sequencer #(
  parameter int DATA_SIZE = multicore_pkg::DATA_SIZE
) (
  input  logic                  i_aclk,
  input  logic                  i_areset_n,
  input  logic                  i_start,
  input  logic                  i_flush,
  input  multicore_pkg::t_mdop  i_op,
  input  logic [DATA_SIZE-1:0]  i_op_a,
  input  logic [DATA_SIZE-1:0]  i_op_b,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DATA_SIZE-1:0]  o_result
);

  import multicore_pkg::*;

  localparam int W = DATA_SIZE;

  t_muldiv_state  state_q, state_d;
  t_mdop          op_q;
  logic           sign_q;
  logic [W-1:0]   result_q, result_d;
  logic           load_result, core_load, core_step, core_last;
  logic [2*W-1:0] core_acc;

  logic           sa, sb, sign_d, accept;
  logic [W-1:0]   abs_a, abs_b;
  logic           special;
  logic [W-1:0]   special_res;
  logic [2*W-1:0] prod;
  logic [W-1:0]   div_word, final_res;

  assign accept = (state_q == IDLE) && i_start && !i_flush;

  // Only the signed operands of each op contribute a sign.
  assign sa     = (i_op == MULH || i_op == MULHSU || i_op == DIV || i_op == REM) && i_op_a[W-1];
  assign sb     = (i_op == MULH || i_op == DIV || i_op == REM) && i_op_b[W-1];
  assign abs_a  = sa ? -i_op_a : i_op_a;
  assign abs_b  = sb ? -i_op_b : i_op_b;
  assign sign_d = md_is_rem(i_op) ? sa : (sa ^ sb);

  always_comb begin
    special     = 1'b0;
    special_res = '0;
    if (md_is_div(i_op) && i_op_b == '0) begin
      special     = 1'b1;
      special_res = md_is_rem(i_op) ? i_op_a : '1;
    end else if ((i_op == DIV || i_op == REM) &&
                 i_op_a == {1'b1, {(W-1){1'b0}}} && i_op_b == '1) begin
      special     = 1'b1;
      special_res = md_is_rem(i_op) ? '0 : i_op_a;
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [W:0]     fast_a, fast_b;
  logic signed [2*W+1:0] fast_p;
  logic                  unused_fast_hi;
  logic [W-1:0]          fast_res;
  assign fast_a         = {(i_op == MULH || i_op == MULHSU) && i_op_a[W-1], i_op_a};
  assign fast_b         = {(i_op == MULH) && i_op_b[W-1], i_op_b};
  assign fast_p         = fast_a * fast_b;
  assign unused_fast_hi = ^fast_p[2*W+1:2*W];
  assign fast_res       = (i_op == MUL) ? fast_p[W-1:0] : fast_p[2*W-1:W];
`endif

  // Sign fix applies to the full product, or to the selected quotient/remainder word.
  assign prod      = sign_q ? -core_acc : core_acc;
  assign div_word  = md_is_rem(op_q) ? core_acc[2*W-1:W] : core_acc[W-1:0];
  assign final_res = md_is_div(op_q) ? (sign_q ? -div_word : div_word)
                   : (op_q == MUL)   ? prod[W-1:0] : prod[2*W-1:W];

  always_comb begin
    state_d     = state_q;
    core_load   = 1'b0;
    core_step   = 1'b0;
    load_result = 1'b0;
    result_d    = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          core_load = 1'b1;
          if (special) begin
            state_d     = DONE;
            load_result = 1'b1;
            result_d    = special_res;
          end
`ifdef MULDIV_FAST_MUL_EN
          else if (!md_is_div(i_op)) begin
            state_d     = DONE;
            load_result = 1'b1;
            result_d    = fast_res;
          end
`endif
          else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        core_step = 1'b1;
        if (core_last) begin
          state_d     = DONE;
          load_result = 1'b1;
          result_d    = final_res;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (i_flush) begin
      state_d     = IDLE;
      load_result = 1'b0;
    end
  end

  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state_q  <= IDLE;
      op_q     <= MUL;
      sign_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q   <= i_op;
        sign_q <= sign_d;
      end
      if (load_result) result_q <= result_d;
    end
  end

  muldiv_iter_core #(.W(W)) u_core (
    .i_aclk     (i_aclk),
    .i_areset_n (i_areset_n),
    .i_load     (core_load),
    .i_step     (core_step),
    .i_div      (md_is_div(op_q)),
    .i_a        (abs_a),
    .i_b        (abs_b),
    .o_acc_next (core_acc),
    .o_last     (core_last)
  );

  // Gated by reset so the stall drops immediately even with i_start still high.
  assign o_busy   = i_areset_n && (accept || state_q == RUN);
  assign o_done   = (state_q == DONE);
  assign o_result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer; honours MULDIV_FAST_MUL_EN for multiply latency.
module tb_muldiv_sequencer;
  import multicore_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MLAT = 1;
`else
  localparam int MLAT = 33;
`endif
  localparam int DLAT = 33;

  logic        i_aclk = 1'b0;
  logic        i_areset_n;
  logic        i_start;
  logic        i_flush;
  t_mdop       i_op;
  logic [31:0] i_op_a, i_op_b;
  logic        o_busy, o_done;
  logic [31:0] o_result;

  int n_assert = 0;
  int n_fail   = 0;

  muldiv_sequencer dut (
    .i_aclk     (i_aclk),
    .i_areset_n (i_areset_n),
    .i_start    (i_start),
    .i_flush    (i_flush),
    .i_op       (i_op),
    .i_op_a     (i_op_a),
    .i_op_b     (i_op_b),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_result   (o_result)
  );

  always #5 i_aclk = ~i_aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_aclk);
    #1;
  endtask

  // Starts an op in the current cycle, holds i_start through DONE, then drops it.
  task automatic run_op(input string tag, input t_mdop op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int   lat;
    logic done;
    logic busy_ok;
    i_op = op; i_op_a = a; i_op_b = b; i_start = 1'b1;
    #1;
    chk({tag, "_busy_c0"}, {31'd0, o_busy}, 32'd1);
    lat = 0; done = 1'b0; busy_ok = 1'b1;
    while (!done && lat < 60) begin
      step();
      lat++;
      if (o_done) done = 1'b1;
      else if (!o_busy) busy_ok = 1'b0;
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_busy_run"}, {31'd0, busy_ok}, 32'd1);
    chk({tag, "_result"}, o_result, exp_res);
    chk({tag, "_busy_done"}, {31'd0, o_busy}, 32'd0);
    step();
    i_start = 1'b0;
    #1;
    chk({tag, "_single_done"}, {31'd0, o_done}, 32'd0);
  endtask

  initial begin
    logic seen_done;
    i_areset_n = 1'b0; i_start = 1'b0; i_flush = 1'b0;
    i_op = MUL; i_op_a = '0; i_op_b = '0;
    step(); step();
    chk("rst_busy",   {31'd0, o_busy}, 32'd0);
    chk("rst_done",   {31'd0, o_done}, 32'd0);
    chk("rst_result", o_result, 32'd0);
    i_areset_n = 1'b1;
    step();

    run_op("mul_7_m3",   MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, MLAT);
    run_op("mulhu_ff",   MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MLAT);
    run_op("mulh_ff",    MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MLAT);
    run_op("mulhsu_ff",  MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MLAT);
    run_op("mul_shift",  MUL,    32'h1234_5678, 32'h0000_0010, 32'h2345_6780, MLAT);
    run_op("div_m7_2",   DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, DLAT);
    run_op("rem_m7_2",   REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, DLAT);
    run_op("div_20_m6",  DIV,    32'd20,        32'hFFFF_FFFA, 32'hFFFF_FFFD, DLAT);
    run_op("rem_20_m6",  REM,    32'd20,        32'hFFFF_FFFA, 32'd2,         DLAT);
    run_op("divu_100_7", DIVU,   32'd100,       32'd7,         32'd14,        DLAT);
    run_op("remu_100_7", REMU,   32'd100,       32'd7,         32'd2,         DLAT);
    run_op("divu_5_0",   DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    run_op("remu_5_0",   REMU,   32'd5,         32'd0,         32'd5,         1);
    run_op("div_ovf",    DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf",    REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
    run_op("rem_m5_0",   REM,    32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1);
    run_op("divu_big",   DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         DLAT);

    // Flush a DIV in cycle 10.
    i_op = DIV; i_op_a = 32'd100; i_op_b = 32'd7; i_start = 1'b1;
    seen_done = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (o_done) seen_done = 1'b1;
    end
    i_flush = 1'b1;
    step();
    i_flush = 1'b0; i_start = 1'b0;
    #1;
    chk("flush_busy_c11", {31'd0, o_busy}, 32'd0);
    chk("flush_no_done",  {31'd0, seen_done | o_done}, 32'd0);
    run_op("mul_after_flush", MUL, 32'd6, 32'd7, 32'd42, MLAT);
    seen_done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (o_done) seen_done = 1'b1;
    end
    chk("no_second_done", {31'd0, seen_done}, 32'd0);

    // Reset in cycle 5 of a DIV, with i_start still high.
    i_op = DIV; i_op_a = 32'd1000; i_op_b = 32'd3; i_start = 1'b1;
    for (int c = 0; c < 5; c++) step();
    i_areset_n = 1'b0;
    #1;
    chk("midrst_busy",   {31'd0, o_busy}, 32'd0);
    chk("midrst_done",   {31'd0, o_done}, 32'd0);
    chk("midrst_result", o_result, 32'd0);
    step();
    chk("midrst_busy_held", {31'd0, o_busy}, 32'd0);
    i_start = 1'b0;
    i_areset_n = 1'b1;
    step();
    run_op("divu_9_3", DIVU, 32'd9, 32'd3, 32'd3, DLAT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
